rps_round_judge: RTL and testbench

Downstream referee stage of the rock-paper-scissors game. It consumes the player's decoded punch and the computer's 2-bit random pick, decides each round, holds the result for a visible reveal period, and keeps the match score up to a first-to-N win. It drives the score and result fields that the LED-matrix and 7-segment display logic render.

---
 rtl/rps_pkg.sv | 50 +++++
 rtl/rps_tick_counter.sv | 29 ++
 rtl/rps_round_judge.sv | 125 ++++++++++++
 tb/tb_rps_round_judge.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rps_pkg.sv
// Shared rock-paper-scissors encodings, referee state enum and judging helpers.
// Used by the computer-pick, referee and display stages.
package rps_pkg;

  typedef enum logic [1:0] {
    SCISSORS = 2'b00,
    STONE    = 2'b01,
    PAPER    = 2'b10,
    NONE     = 2'b11
  } move_e;

  typedef enum logic [1:0] {
    RES_NONE   = 2'b00,
    RES_PLAYER = 2'b01,
    RES_CPU    = 2'b10,
    RES_DRAW   = 2'b11
  } result_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_REVEAL = 2'b01,
    ST_UPDATE = 2'b10,
    ST_OVER   = 2'b11
  } judge_state_e;

  localparam logic [3:0] ROUND_MAX = 4'd15;

  // a beats b when a is the move after b in the scissors->stone->paper cycle
  function automatic logic rps_beats(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] succ;
    succ = (b == PAPER) ? SCISSORS : b + 2'd1;
    return a == succ;
  endfunction

  function automatic logic rps_playable(input logic [1:0] m);
    return m != NONE;
  endfunction

  function automatic logic [1:0] rps_judge(input logic [1:0] player, input logic [1:0] cpu);
    logic [1:0] res;
    if (player == cpu)
      res = RES_DRAW;
    else if (rps_beats(player, cpu))
      res = RES_PLAYER;
    else
      res = RES_CPU;
    return res;
  endfunction

endpackage

// File: rtl/rps_tick_counter.sv
// Counts tick pulses while enabled; done is combinational on the final counted tick.
// Zero latency on done; load/Clear restart the count from zero.
module rps_tick_counter
  import rps_pkg::*;
#(
  parameter int TICKS = 4
) (
  input  logic CLK,
  input  logic Clear,
  input  logic load,
  input  logic en,
  input  logic tick,
  output logic done
);

  localparam logic [3:0] LAST = 4'(TICKS - 1);

  logic [3:0] cnt;

  assign done = en && tick && (cnt == LAST);

  always_ff @(posedge CLK) begin
    if (Clear || load)
      cnt <= 4'd0;
    else if (en && tick)
      cnt <= done ? 4'd0 : cnt + 4'd1;
  end

endmodule

// File: rtl/rps_round_judge.sv
// Referee: captures a round, holds the result for REVEAL_TICKS ticks, then scores it.
// Punches are only taken in IDLE (ready); anything thrown elsewhere is dropped, never queued.
module rps_round_judge
  import rps_pkg::*;
#(
  parameter int WIN_TARGET   = 3,
  parameter int REVEAL_TICKS = 4
) (
  input  logic       CLK,
  input  logic       Clear,
  input  logic       tick,
  input  logic       punch_valid,
  input  logic [1:0] punch_move,
  input  logic [1:0] cpu_move,
  input  logic       new_match,
  output logic       ready,
  output logic       reveal,
  output logic [1:0] player_q,
  output logic [1:0] cpu_q,
  output logic [1:0] result,
  output logic [2:0] player_score,
  output logic [2:0] cpu_score,
  output logic [3:0] round_count,
  output logic       match_over,
  output logic       player_won
);

  localparam logic [2:0] TARGET = 3'(WIN_TARGET);

  judge_state_e state_q, state_d;

  logic       accept;
  logic       reveal_done;
  logic [1:0] player_mv_q, cpu_mv_q, result_q;
  logic [2:0] player_score_q, cpu_score_q;
  logic [2:0] player_score_nxt, cpu_score_nxt;
  logic [3:0] round_count_q;
  logic       target_hit;

  rps_tick_counter #(
    .TICKS(REVEAL_TICKS)
  ) u_tick_counter (
    .CLK  (CLK),
    .Clear(Clear),
    .load (new_match || accept),
    .en   (state_q == ST_REVEAL),
    .tick (tick),
    .done (reveal_done)
  );

  // Scores after the pending round is applied; only committed in UPDATE
  always_comb begin
    player_score_nxt = player_score_q;
    cpu_score_nxt    = cpu_score_q;
    if (result_q == RES_PLAYER)
      player_score_nxt = player_score_q + 3'd1;
    else if (result_q == RES_CPU)
      cpu_score_nxt = cpu_score_q + 3'd1;
    target_hit = (player_score_nxt == TARGET) || (cpu_score_nxt == TARGET);
  end

  always_ff @(posedge CLK) begin
    if (Clear)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (punch_valid && rps_playable(punch_move) && rps_playable(cpu_move)) begin
          accept  = 1'b1;
          state_d = ST_REVEAL;
        end
      end
      ST_REVEAL: begin
        if (reveal_done)
          state_d = ST_UPDATE;
      end
      ST_UPDATE: state_d = target_hit ? ST_OVER : ST_IDLE;
      ST_OVER:   state_d = ST_OVER;
      default:   state_d = ST_IDLE;
    endcase
    // new_match outranks any punch and aborts a reveal before it is scored
    if (new_match) begin
      accept  = 1'b0;
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge CLK) begin
    if (Clear || new_match) begin
      player_mv_q    <= 2'b00;
      cpu_mv_q       <= 2'b00;
      result_q       <= RES_NONE;
      player_score_q <= 3'd0;
      cpu_score_q    <= 3'd0;
      round_count_q  <= 4'd0;
    end else if (accept) begin
      player_mv_q <= punch_move;
      cpu_mv_q    <= cpu_move;
      result_q    <= rps_judge(punch_move, cpu_move);
    end else if (state_q == ST_UPDATE) begin
      player_score_q <= player_score_nxt;
      cpu_score_q    <= cpu_score_nxt;
      if (round_count_q != ROUND_MAX)
        round_count_q <= round_count_q + 4'd1;
    end
  end

  assign ready        = (state_q == ST_IDLE);
  assign reveal       = (state_q == ST_REVEAL);
  assign match_over   = (state_q == ST_OVER);
  assign player_won   = match_over && (player_score_q == TARGET);
  assign player_q     = player_mv_q;
  assign cpu_q        = cpu_mv_q;
  assign result       = result_q;
  assign player_score = player_score_q;
  assign cpu_score    = cpu_score_q;
  assign round_count  = round_count_q;

endmodule

// File: tb/tb_rps_round_judge.sv
// Bench for rps_round_judge: default instance (first to 3) plus a first-to-7 instance for saturation.
module tb_rps_round_judge;

  localparam int WT = 3;
  localparam int RT = 4;

  logic       CLK = 1'b0;
  logic       Clear = 1'b1;
  logic       tick = 1'b0;
  logic       punch_valid = 1'b0;
  logic [1:0] punch_move = 2'b00;
  logic [1:0] cpu_move = 2'b00;
  logic       new_match = 1'b0;
  logic       punch_valid7 = 1'b0;
  logic       new_match7 = 1'b0;

  logic       ready, reveal, match_over, player_won;
  logic [1:0] player_q, cpu_q, result;
  logic [2:0] player_score, cpu_score;
  logic [3:0] round_count;

  logic       ready7, reveal7, match_over7, player_won7;
  logic [1:0] player_q7, cpu_q7, result7;
  logic [2:0] player_score7, cpu_score7;
  logic [3:0] round_count7;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0] res;
    logic [2:0] ps;
    logic [2:0] cs;
    logic [3:0] rc;
    logic       over;
  } exp_t;

  exp_t sb_q[$];

  logic [2:0] m_ps, m_cs;
  logic [3:0] m_rc;
  logic       m_over;

  always #5 CLK = ~CLK;

  rps_round_judge #(.WIN_TARGET(WT), .REVEAL_TICKS(RT)) dut (
    .CLK(CLK), .Clear(Clear), .tick(tick), .punch_valid(punch_valid),
    .punch_move(punch_move), .cpu_move(cpu_move), .new_match(new_match),
    .ready(ready), .reveal(reveal), .player_q(player_q), .cpu_q(cpu_q),
    .result(result), .player_score(player_score), .cpu_score(cpu_score),
    .round_count(round_count), .match_over(match_over), .player_won(player_won)
  );

  rps_round_judge #(.WIN_TARGET(7), .REVEAL_TICKS(RT)) dut7 (
    .CLK(CLK), .Clear(Clear), .tick(tick), .punch_valid(punch_valid7),
    .punch_move(punch_move), .cpu_move(cpu_move), .new_match(new_match7),
    .ready(ready7), .reveal(reveal7), .player_q(player_q7), .cpu_q(cpu_q7),
    .result(result7), .player_score(player_score7), .cpu_score(cpu_score7),
    .round_count(round_count7), .match_over(match_over7), .player_won(player_won7)
  );

  // Reference rule table written out pair by pair
  function automatic logic [1:0] ref_result(input logic [1:0] p, input logic [1:0] c);
    logic [3:0] pc;
    pc = {p, c};
    case (pc)
      4'b01_00, 4'b10_01, 4'b00_10: return 2'b01;
      4'b00_01, 4'b01_10, 4'b10_00: return 2'b10;
      default:                      return 2'b11;
    endcase
  endfunction

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic model_reset();
    m_ps = 3'd0; m_cs = 3'd0; m_rc = 4'd0; m_over = 1'b0;
  endtask

  task automatic model_round(input logic [1:0] p, input logic [1:0] c, output exp_t e);
    logic [1:0] r;
    r = ref_result(p, c);
    if (r == 2'b01) m_ps = m_ps + 3'd1;
    if (r == 2'b10) m_cs = m_cs + 3'd1;
    if (m_rc != 4'd15) m_rc = m_rc + 4'd1;
    m_over = (m_ps == 3'(WT)) || (m_cs == 3'(WT));
    e.res = r; e.ps = m_ps; e.cs = m_cs; e.rc = m_rc; e.over = m_over;
  endtask

  task automatic throw(input logic [1:0] p, input logic [1:0] c);
    punch_valid = 1'b1; punch_move = p; cpu_move = c;
    step();
    punch_valid = 1'b0;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
    end
  endtask

  task automatic pulse_new_match();
    new_match = 1'b1;
    step();
    new_match = 1'b0;
    model_reset();
  endtask

  task automatic finish_round(input string name);
    exp_t e;
    step();
    e = sb_q.pop_front();
    checks++;
    if ({result, player_score, cpu_score, round_count, match_over, ready} !==
        {e.res, e.ps, e.cs, e.rc, e.over, ~e.over}) begin
      errors++;
      $display("FAIL %s score: got res=%b ps=%0d cs=%0d rc=%0d over=%b rdy=%b want res=%b ps=%0d cs=%0d rc=%0d over=%b",
               name, result, player_score, cpu_score, round_count, match_over, ready,
               e.res, e.ps, e.cs, e.rc, e.over);
    end
  endtask

  task automatic play_round(input logic [1:0] p, input logic [1:0] c, input string name);
    exp_t e;
    model_round(p, c, e);
    sb_q.push_back(e);
    throw(p, c);
    checks++;
    if ({reveal, result, player_q, cpu_q} !== {1'b1, e.res, p, c}) begin
      errors++;
      $display("FAIL %s reveal: got rev=%b res=%b pq=%b cq=%b want rev=1 res=%b pq=%b cq=%b",
               name, reveal, result, player_q, cpu_q, e.res, p, c);
    end
    tick_n(RT);
    finish_round(name);
  endtask

  task automatic test_reset();
    exp_t e;
    Clear = 1'b1;
    step(); step();
    Clear = 1'b0;
    model_reset();
    checks++;
    if ({ready, reveal, player_q, cpu_q, result, player_score, cpu_score, round_count, match_over, player_won}
        !== {1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b rev=%b pq=%b cq=%b res=%b ps=%0d cs=%0d rc=%0d ov=%b pw=%b want rdy=1 rest 0",
               ready, reveal, player_q, cpu_q, result, player_score, cpu_score, round_count, match_over, player_won);
    end
    model_round(2'b01, 2'b00, e);
    sb_q.push_back(e);
    throw(2'b01, 2'b00);
    checks++;
    if ({ready, reveal, result} !== {1'b0, 1'b1, 2'b01}) begin
      errors++;
      $display("FAIL first_accept: got rdy=%b rev=%b res=%b want rdy=0 rev=1 res=01", ready, reveal, result);
    end
    tick_n(RT);
    checks++;
    if ({ready, reveal, player_score} !== {1'b0, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL update_cycle: got rdy=%b rev=%b ps=%0d want rdy=0 rev=0 ps=0", ready, reveal, player_score);
    end
    finish_round("first_round");
  endtask

  task automatic test_rule_matrix();
    logic [1:0] pairs [9][2];
    pairs = '{'{2'd0,2'd0}, '{2'd0,2'd1}, '{2'd0,2'd2}, '{2'd1,2'd0}, '{2'd1,2'd1},
              '{2'd1,2'd2}, '{2'd2,2'd0}, '{2'd2,2'd1}, '{2'd2,2'd2}};
    pulse_new_match();
    for (int i = 0; i < 9; i++) begin
      if (m_over) pulse_new_match();
      play_round(pairs[i][0], pairs[i][1], $sformatf("matrix_%0d%0d", pairs[i][0], pairs[i][1]));
    end
  endtask

  task automatic test_match_end();
    pulse_new_match();
    play_round(2'd1, 2'd0, "match_w1");
    play_round(2'd0, 2'd0, "match_d1");
    play_round(2'd2, 2'd1, "match_w2");
    play_round(2'd1, 2'd1, "match_d2");
    play_round(2'd0, 2'd2, "match_w3");
    checks++;
    if ({match_over, player_won, round_count} !== {1'b1, 1'b1, 4'd5}) begin
      errors++;
      $display("FAIL match_over: got ov=%b pw=%b rc=%0d want ov=1 pw=1 rc=5", match_over, player_won, round_count);
    end
    throw(2'd1, 2'd0);
    tick_n(RT); step();
    checks++;
    if ({match_over, reveal, player_q, round_count, player_score} !== {1'b1, 1'b0, 2'd0, 4'd5, 3'd3}) begin
      errors++;
      $display("FAIL over_ignores_punch: got ov=%b rev=%b pq=%b rc=%0d ps=%0d want ov=1 rev=0 pq=0 rc=5 ps=3",
               match_over, reveal, player_q, round_count, player_score);
    end
    pulse_new_match();
    checks++;
    if ({ready, match_over, player_won, player_score, cpu_score, round_count} !== {1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 4'd0}) begin
      errors++;
      $display("FAIL new_match_after_over: got rdy=%b ov=%b pw=%b ps=%0d cs=%0d rc=%0d want rdy=1 rest 0",
               ready, match_over, player_won, player_score, cpu_score, round_count);
    end
  endtask

  task automatic test_ignored();
    exp_t e;
    throw(2'd3, 2'd0);
    checks++;
    if ({ready, reveal} !== 2'b10) begin
      errors++;
      $display("FAIL none_player: got rdy=%b rev=%b want rdy=1 rev=0", ready, reveal);
    end
    throw(2'd0, 2'd3);
    checks++;
    if ({ready, reveal} !== 2'b10) begin
      errors++;
      $display("FAIL none_cpu: got rdy=%b rev=%b want rdy=1 rev=0", ready, reveal);
    end
    model_round(2'd0, 2'd1, e);
    sb_q.push_back(e);
    throw(2'd0, 2'd1);
    tick_n(1);
    throw(2'd2, 2'd2);
    checks++;
    if ({reveal, player_q, cpu_q, result} !== {1'b1, 2'd0, 2'd1, 2'b10}) begin
      errors++;
      $display("FAIL punch_in_reveal: got rev=%b pq=%b cq=%b res=%b want rev=1 pq=00 cq=01 res=10",
               reveal, player_q, cpu_q, result);
    end
    tick_n(RT - 1);
    finish_round("reveal_punch_round");
    model_round(2'd2, 2'd2, e);
    sb_q.push_back(e);
    tick = 1'b1;
    throw(2'd2, 2'd2);
    tick = 1'b0;
    tick_n(RT - 1);
    checks++;
    if (reveal !== 1'b1) begin
      errors++;
      $display("FAIL accept_tick_counted: got rev=%b want rev=1", reveal);
    end
    tick_n(1);
    finish_round("accept_tick_round");
  endtask

  task automatic test_new_match_abort();
    throw(2'd1, 2'd0);
    tick_n(2);
    pulse_new_match();
    checks++;
    if ({ready, reveal, result, player_q, cpu_q, player_score, cpu_score, round_count}
        !== {1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 4'd0}) begin
      errors++;
      $display("FAIL abort_reveal: got rdy=%b rev=%b res=%b pq=%b cq=%b ps=%0d cs=%0d rc=%0d want rdy=1 rest 0",
               ready, reveal, result, player_q, cpu_q, player_score, cpu_score, round_count);
    end
    tick_n(RT); step();
    checks++;
    if ({ready, player_score, cpu_score, round_count} !== {1'b1, 3'd0, 3'd0, 4'd0}) begin
      errors++;
      $display("FAIL abort_no_score: got rdy=%b ps=%0d cs=%0d rc=%0d want rdy=1 ps=0 cs=0 rc=0",
               ready, player_score, cpu_score, round_count);
    end
    new_match = 1'b1;
    throw(2'd1, 2'd0);
    new_match = 1'b0;
    checks++;
    if ({ready, reveal, player_q, result} !== {1'b1, 1'b0, 2'b00, 2'b00}) begin
      errors++;
      $display("FAIL new_match_beats_punch: got rdy=%b rev=%b pq=%b res=%b want rdy=1 rev=0 pq=00 res=00",
               ready, reveal, player_q, result);
    end
  endtask

  task automatic test_clear_mid_reveal();
    pulse_new_match();
    play_round(2'd1, 2'd0, "pre_clear_w1");
    play_round(2'd2, 2'd1, "pre_clear_w2");
    play_round(2'd0, 2'd1, "pre_clear_c1");
    throw(2'd2, 2'd1);
    tick_n(1);
    Clear = 1'b1;
    step();
    Clear = 1'b0;
    model_reset();
    checks++;
    if ({ready, reveal, player_q, cpu_q, result, player_score, cpu_score, round_count, match_over, player_won}
        !== {1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL clear_mid_reveal: got rdy=%b rev=%b pq=%b cq=%b res=%b ps=%0d cs=%0d rc=%0d ov=%b pw=%b want rdy=1 rest 0",
               ready, reveal, player_q, cpu_q, result, player_score, cpu_score, round_count, match_over, player_won);
    end
  endtask

  task automatic test_round_saturation();
    exp_t e;
    new_match7 = 1'b1;
    step();
    new_match7 = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      e.res = 2'b11; e.ps = 3'd0; e.cs = 3'd0; e.over = 1'b0;
      e.rc = (i > 15) ? 4'd15 : 4'(i);
      sb_q.push_back(e);
      punch_valid7 = 1'b1; punch_move = 2'(i % 3); cpu_move = 2'(i % 3);
      step();
      punch_valid7 = 1'b0;
      tick_n(RT);
      step();
      e = sb_q.pop_front();
      checks++;
      if ({round_count7, player_score7, cpu_score7, result7, ready7} !== {e.rc, e.ps, e.cs, e.res, 1'b1}) begin
        errors++;
        $display("FAIL saturate_%0d: got rc=%0d ps=%0d cs=%0d res=%b rdy=%b want rc=%0d ps=0 cs=0 res=11 rdy=1",
                 i, round_count7, player_score7, cpu_score7, result7, ready7, e.rc);
      end
    end
    checks++;
    if ({reveal7, match_over7, player_won7, player_q7, cpu_q7} !== {1'b0, 1'b0, 1'b0, 2'd2, 2'd2}) begin
      errors++;
      $display("FAIL saturate_final: got rev=%b ov=%b pw=%b pq=%b cq=%b want rev=0 ov=0 pw=0 pq=10 cq=10",
               reveal7, match_over7, player_won7, player_q7, cpu_q7);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rule_matrix();
    test_match_end();
    test_ignored();
    test_new_match_abort();
    test_clear_mid_reveal();
    test_round_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
